// File: rtl/sn_popcount_pipe_if.sv
// Beat-in / result-out bundle for sn_popcount_pipe.
// The slave modport is the popcount block; the master modport is the environment around it.
interface sn_popcount_pipe_if #(
    parameter int N     = 16,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic [N-1:0]     out_sorted;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_sorted, out_ovf
    );

    modport master (
        output in_valid, in_data, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_sorted, out_ovf
    );
endinterface

// File: rtl/sn_popcount_pipe.sv
// Three-stage popcount: sorting-network thermometer, thermometer-to-binary, then
// per-beat result or saturating per-packet accumulation.
module sn_popcount_pipe #(
    parameter int N     = 16,
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sn_popcount_pipe_if.slave     bus,
    output logic                  dbg_in_pkt
);
    localparam int CW = $clog2(N + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    // Handshake: a beat moves on a rising edge when in_valid && in_ready; a result
    // leaves when out_valid && out_ready. The whole pipe advances only when en=1.
    typedef enum logic {ST_START, ST_IN_PKT} pkt_state_e;

    pkt_state_e       state_q, state_d;
    logic             pkt_mode_q, pkt_mode_d;
    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_mode_q, s1_mode_d;
    logic [N-1:0]     s1_thermo_q, s1_thermo_d;
    logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, s2_mode_q, s2_mode_d;
    logic [N-1:0]     s2_thermo_q, s2_thermo_d;
    logic [CW-1:0]    s2_count_q, s2_count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic [ACC_W-1:0] out_count_q, out_count_d;
    logic [N-1:0]     out_sorted_q, out_sorted_d;

    logic             en, accept, beat_mode;
    logic [N-1:0]     sorted;
    logic [CW-1:0]    therm_cnt;
    logic [ACC_W-1:0] base, sum_sat;
    logic [ACC_W:0]   sum;

    assign en           = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & en;
    assign bus.in_ready = en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_sorted = out_sorted_q;
    assign bus.out_ovf    = out_ovf_q;
    assign dbg_in_pkt     = (state_q == ST_IN_PKT);

    // Packet-start tracker: mode is taken from the first beat and reused until in_last.
    always_comb begin
        state_d    = state_q;
        pkt_mode_d = pkt_mode_q;
        beat_mode  = (state_q == ST_START) ? bus.in_mode : pkt_mode_q;
        if (accept) begin
            if (state_q == ST_START) pkt_mode_d = bus.in_mode;
            state_d = bus.in_last ? ST_START : ST_IN_PKT;
        end
    end

    // Odd-even transposition network; OR goes low so ones gather at the LSB end.
    always_comb begin
        sorted = bus.in_data;
        for (int s = 0; s < N; s++) begin
            for (int i = s % 2; i + 1 < N; i += 2) begin
                {sorted[i+1], sorted[i]} = {sorted[i] & sorted[i+1], sorted[i] | sorted[i+1]};
            end
        end
    end

    always_comb begin
        therm_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (s1_thermo_q[i]) therm_cnt = CW'(i + 1);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_thermo_d = s1_thermo_q;
        s1_last_d   = s1_last_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        s2_thermo_d = s2_thermo_q;
        s2_count_d  = s2_count_q;
        s2_last_d   = s2_last_q;
        s2_mode_d   = s2_mode_q;
        if (en) begin
            s1_valid_d  = accept;
            s1_thermo_d = sorted;
            s1_last_d   = bus.in_last;
            s1_mode_d   = beat_mode;
            s2_valid_d  = s1_valid_q;
            s2_thermo_d = s1_thermo_q;
            s2_count_d  = therm_cnt;
            s2_last_d   = s1_last_q;
            s2_mode_d   = s1_mode_q;
        end
    end

    // Stage 3: per-beat modes start from zero, so a single-beat packet equals mode 0.
    always_comb begin
        base         = s2_mode_q ? acc_q : '0;
        sum          = {1'b0, base} + {{(ACC_W + 1 - CW){1'b0}}, s2_count_q};
        sum_sat      = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
        acc_d        = acc_q;
        sticky_d     = sticky_q;
        out_valid_d  = out_valid_q;
        out_count_d  = out_count_q;
        out_sorted_d = out_sorted_q;
        out_ovf_d    = out_ovf_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (!s2_mode_q || s2_last_q) begin
                    out_valid_d  = 1'b1;
                    out_count_d  = sum_sat;
                    out_sorted_d = s2_thermo_q;
                    out_ovf_d    = (s2_mode_q & sticky_q) | sum[ACC_W];
                    acc_d        = '0;
                    sticky_d     = 1'b0;
                end else begin
                    acc_d    = sum_sat;
                    sticky_d = sticky_q | sum[ACC_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_START;
            pkt_mode_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_thermo_q  <= '0;
            s1_last_q    <= 1'b0;
            s1_mode_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_thermo_q  <= '0;
            s2_count_q   <= '0;
            s2_last_q    <= 1'b0;
            s2_mode_q    <= 1'b0;
            acc_q        <= '0;
            sticky_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
            out_sorted_q <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_mode_q   <= pkt_mode_d;
            s1_valid_q   <= s1_valid_d;
            s1_thermo_q  <= s1_thermo_d;
            s1_last_q    <= s1_last_d;
            s1_mode_q    <= s1_mode_d;
            s2_valid_q   <= s2_valid_d;
            s2_thermo_q  <= s2_thermo_d;
            s2_count_q   <= s2_count_d;
            s2_last_q    <= s2_last_d;
            s2_mode_q    <= s2_mode_d;
            acc_q        <= acc_d;
            sticky_q     <= sticky_d;
            out_valid_q  <= out_valid_d;
            out_count_q  <= out_count_d;
            out_sorted_q <= out_sorted_d;
            out_ovf_q    <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_sn_popcount_pipe.sv
// Directed bench for sn_popcount_pipe (N=16, ACC_W=8) with hand-computed expectations.
module tb_sn_popcount_pipe;
    logic clk;
    logic rst_n;
    logic dbg_in_pkt;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0]  got_count_q[$];
    logic        got_ovf_q[$];
    logic [15:0] got_sorted_q[$];

    sn_popcount_pipe_if #(.N(16), .ACC_W(8)) bus ();

    sn_popcount_pipe #(.N(16), .ACC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .dbg_in_pkt (dbg_in_pkt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Results are recorded half a cycle before the edge that completes their handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got_count_q.push_back(bus.out_count);
            got_ovf_q.push_back(bus.out_ovf);
            got_sorted_q.push_back(bus.out_sorted);
        end
    end

    task automatic clear_results();
        got_count_q.delete();
        got_ovf_q.delete();
        got_sorted_q.delete();
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last, input logic mode);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_mode  = mode;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%b required 1 for beat %h", bus.in_ready, d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int cyc = 0;
        while (got_count_q.size() < n && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        #2;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.out_count); end
        n_vec++; if (bus.out_sorted !== 16'h0000) begin n_err++; $display("FAIL rst_sorted: got %h want 0000", bus.out_sorted); end
        n_vec++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", bus.out_ovf); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mode0_stream();
        logic [15:0] beats[3]  = '{16'h0000, 16'hFFFF, 16'h00F1};
        logic        exp_v[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  exp_c[6]  = '{8'd0, 8'd0, 8'd0, 8'd16, 8'd5, 8'd5};
        logic [15:0] exp_s[6]  = '{16'h0, 16'h0, 16'h0000, 16'hFFFF, 16'h001F, 16'h001F};
        clear_results();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = (k < 3);
            bus.in_data  = (k < 3) ? beats[k] : 16'h0;
            bus.in_last  = 1'b1;
            bus.in_mode  = 1'b0;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            n_vec++;
            if (bus.out_valid !== exp_v[k]) begin
                n_err++; $display("FAIL m0_valid[edge %0d]: got %b want %b", k + 1, bus.out_valid, exp_v[k]);
            end
            if (exp_v[k]) begin
                n_vec++;
                if (bus.out_count !== exp_c[k]) begin
                    n_err++; $display("FAIL m0_count[edge %0d]: got %0d want %0d", k + 1, bus.out_count, exp_c[k]);
                end
                n_vec++;
                if (bus.out_sorted !== exp_s[k] || bus.out_ovf !== 1'b0) begin
                    n_err++; $display("FAIL m0_sorted[edge %0d]: got %h/%b want %h/0", k + 1, bus.out_sorted, bus.out_ovf, exp_s[k]);
                end
            end
        end
    endtask

    task automatic test_packet_sum();
        clear_results();
        send_beat(16'h000F, 1'b0, 1'b1);
        send_beat(16'h0101, 1'b0, 1'b1);
        send_beat(16'hFFFF, 1'b1, 1'b1);
        wait_results(1);
        n_vec++; if (got_count_q.size() != 1) begin n_err++; $display("FAIL pkt_nres: got %0d want 1", got_count_q.size()); end
        n_vec++; if (got_count_q[0] !== 8'd22) begin n_err++; $display("FAIL pkt_count: got %0d want 22", got_count_q[0]); end
        n_vec++; if (got_ovf_q[0] !== 1'b0) begin n_err++; $display("FAIL pkt_ovf: got %b want 0", got_ovf_q[0]); end
        n_vec++; if (got_sorted_q[0] !== 16'hFFFF) begin n_err++; $display("FAIL pkt_sorted: got %h want FFFF", got_sorted_q[0]); end
    endtask

    task automatic test_saturate();
        clear_results();
        for (int k = 0; k < 17; k++) send_beat(16'hFFFF, (k == 16), 1'b1);
        send_beat(16'h0003, 1'b1, 1'b0);
        wait_results(2);
        n_vec++; if (got_count_q.size() != 2) begin n_err++; $display("FAIL sat_nres: got %0d want 2", got_count_q.size()); end
        n_vec++; if (got_count_q[0] !== 8'd255) begin n_err++; $display("FAIL sat_count: got %0d want 255", got_count_q[0]); end
        n_vec++; if (got_ovf_q[0] !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b want 1", got_ovf_q[0]); end
        n_vec++; if (got_count_q[1] !== 8'd2) begin n_err++; $display("FAIL post_sat_count: got %0d want 2", got_count_q[1]); end
        n_vec++; if (got_ovf_q[1] !== 1'b0) begin n_err++; $display("FAIL post_sat_ovf: got %b want 0", got_ovf_q[1]); end
        n_vec++; if (got_sorted_q[1] !== 16'h0003) begin n_err++; $display("FAIL post_sat_sorted: got %h want 0003", got_sorted_q[1]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] beats[6] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F, 16'h003F};
        logic        exp_rdy[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        exp_ov[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        clear_results();
        bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) send_beat(beats[k], 1'b1, 1'b0);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    n_vec++;
                    if (bus.in_ready !== exp_rdy[k] || bus.out_valid !== exp_ov[k]) begin
                        n_err++;
                        $display("FAIL bp_hold[edge %0d]: in_ready/out_valid got %b/%b want %b/%b",
                                 k + 1, bus.in_ready, bus.out_valid, exp_rdy[k], exp_ov[k]);
                    end
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_results(6);
        n_vec++; if (got_count_q.size() != 6) begin n_err++; $display("FAIL bp_nres: got %0d want 6", got_count_q.size()); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (got_count_q[k] !== 8'(k + 1)) begin
                n_err++; $display("FAIL bp_order[%0d]: got %0d want %0d", k, got_count_q[k], k + 1);
            end
        end
        n_vec++; if (got_sorted_q[5] !== 16'h003F) begin n_err++; $display("FAIL bp_sorted: got %h want 003F", got_sorted_q[5]); end
    endtask

    task automatic test_reset_mid();
        clear_results();
        bus.out_ready = 1'b1;
        send_beat(16'h0003, 1'b0, 1'b1);
        send_beat(16'h0005, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_count !== 8'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", bus.out_count); end
        n_vec++; if (bus.out_sorted !== 16'h0000) begin n_err++; $display("FAIL mid_rst_sorted: got %h want 0000", bus.out_sorted); end
        n_vec++; if (bus.out_valid !== 1'b0 || bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: got %b/%b want 0/0", bus.out_valid, bus.out_ovf); end
        n_vec++; if (dbg_in_pkt !== 1'b0) begin n_err++; $display("FAIL mid_rst_pkt: got %b want 0", dbg_in_pkt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(16'h0007, 1'b1, 1'b0);
        wait_results(1);
        n_vec++; if (got_count_q.size() != 1) begin n_err++; $display("FAIL post_rst_nres: got %0d want 1", got_count_q.size()); end
        n_vec++; if (got_count_q[0] !== 8'd3) begin n_err++; $display("FAIL post_rst_count: got %0d want 3", got_count_q[0]); end
    endtask

    task automatic test_mode_toggle();
        clear_results();
        send_beat(16'h0003, 1'b0, 1'b1);
        send_beat(16'h000F, 1'b0, 1'b0);
        send_beat(16'h0001, 1'b1, 1'b1);
        send_beat(16'h00F0, 1'b1, 1'b1);
        wait_results(2);
        n_vec++; if (got_count_q.size() != 2) begin n_err++; $display("FAIL tog_nres: got %0d want 2", got_count_q.size()); end
        n_vec++; if (got_count_q[0] !== 8'd7) begin n_err++; $display("FAIL tog_count: got %0d want 7", got_count_q[0]); end
        n_vec++; if (got_sorted_q[0] !== 16'h0001) begin n_err++; $display("FAIL tog_sorted: got %h want 0001", got_sorted_q[0]); end
        n_vec++; if (got_count_q[1] !== 8'd4 || got_ovf_q[1] !== 1'b0) begin n_err++; $display("FAIL single_beat: got %0d/%b want 4/0", got_count_q[1], got_ovf_q[1]); end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0;
        bus.in_last  = 1'b0;
        bus.in_mode  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mode0_stream();
        test_packet_sum();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_mode_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
